pdua_datapath: RTL and testbench



---
 rtl/pdua_pkg.sv | 27 ++
 rtl/pdua_alu.sv | 81 ++++++++
 rtl/pdua_datapath.sv | 107 ++++++++++
 tb/tb_pdua_datapath.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdua_pkg.sv
// Shared encodings and constants for the PDUA datapath.
package pdua_pkg;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_AND   = 3'b001,
        OP_XOR   = 3'b010,
        OP_OR    = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_INCB  = 3'b110,
        OP_NOTB  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRL  = 2'b10,
        SH_ROR  = 2'b11
    } shamt_e;

    localparam int unsigned PC_IDX   = 0;
    localparam int unsigned A_IDX    = 3;
    localparam int unsigned ACC_IDX  = 7;
    localparam int unsigned PC_RESET = 1;

endpackage

// File: rtl/pdua_alu.sv
// PDUA ALU with optional post-shifter and carry selection.
// Build option: define PDUA_SHIFTER_EN to enable the post-shifter;
// otherwise shamt_i is ignored and the carry comes from the ALU only.
module pdua_alu
    import pdua_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   selop_i,
    input  logic [1:0]   shamt_i,
    output logic [W-1:0] r_o,
    output logic         c_o
);

    alu_op_e      op;
    logic [W:0]   sum;
    logic         arith;
    logic [W-1:0] alu_res;
    logic         ca;

    assign op = alu_op_e'(selop_i);

    // ALU core; bit W of sum holds carry (add/inc) or borrow (sub)
    always_comb begin
        sum   = '0;
        arith = 1'b0;
        case (op)
            OP_PASSB: sum = {1'b0, b_i};
            OP_AND:   sum = {1'b0, a_i & b_i};
            OP_XOR:   sum = {1'b0, a_i ^ b_i};
            OP_OR:    sum = {1'b0, a_i | b_i};
            OP_ADD: begin
                sum   = {1'b0, a_i} + {1'b0, b_i};
                arith = 1'b1;
            end
            OP_SUB: begin
                sum   = {1'b0, a_i} - {1'b0, b_i};
                arith = 1'b1;
            end
            OP_INCB: begin
                sum   = {1'b0, b_i} + (W+1)'(1);
                arith = 1'b1;
            end
            OP_NOTB:  sum = {1'b0, ~b_i};
        endcase
    end

    assign alu_res = sum[W-1:0];
    assign ca      = arith & sum[W];

`ifdef PDUA_SHIFTER_EN
    // Post-shifter; any active shift overrides the ALU carry
    always_comb begin
        r_o = alu_res;
        c_o = ca;
        case (shamt_e'(shamt_i))
            SH_PASS: ;
            SH_SLL: begin
                r_o = {alu_res[W-2:0], 1'b0};
                c_o = alu_res[W-1];
            end
            SH_SRL: begin
                r_o = {1'b0, alu_res[W-1:1]};
                c_o = alu_res[0];
            end
            SH_ROR: begin
                r_o = {alu_res[0], alu_res[W-1:1]};
                c_o = alu_res[0];
            end
        endcase
    end
`else
    assign r_o = alu_res;
    assign c_o = ca;
    logic unused_shamt;
    assign unused_shamt = ^shamt_i;
`endif

endmodule

// File: rtl/pdua_datapath.sv
// PDUA datapath: register bank, ALU/shifter, flags, IR, MAR, MDR, RAM.
// Build option: PDUA_SHIFTER_EN enables the post-shifter in pdua_alu.
module pdua_datapath
    import pdua_pkg::*;
#(
    parameter int unsigned MAX_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_rdn,
    input  logic                  enaf,
    input  logic [2:0]            selop,
    input  logic [1:0]            shamt,
    output logic                  C,
    output logic                  N,
    output logic                  P,
    output logic                  Z,
    input  logic                  bank_wr_en,
    input  logic [ADDR_WIDTH-1:0] BusB_addr,
    input  logic [ADDR_WIDTH-1:0] BusC_addr,
    input  logic                  sclr,
    input  logic                  ir_en,
    input  logic                  mar_en,
    input  logic                  mdr_en,
    input  logic                  mdr_alu_n,
    output logic [4:0]            out_IR
);

    localparam int unsigned NREG      = 2**ADDR_WIDTH;
    localparam int unsigned RAM_DEPTH = 2**MAX_WIDTH;

    logic [MAX_WIDTH-1:0] bank_q [NREG];
    logic [MAX_WIDTH-1:0] ram_q  [RAM_DEPTH];
    logic [MAX_WIDTH-1:0] mar_q, mdr_q, ir_q;
    logic                 c_q, n_q, p_q, z_q;

    logic [MAX_WIDTH-1:0] busa, busb, busc, shf_r;
    logic                 shf_c;

    assign busa = bank_q[ADDR_WIDTH'(ACC_IDX)];
    assign busb = bank_q[BusB_addr];
    assign busc = mdr_alu_n ? mdr_q : shf_r;

    pdua_alu #(.W(MAX_WIDTH)) u_alu (
        .a_i     (busa),
        .b_i     (busb),
        .selop_i (selop),
        .shamt_i (shamt),
        .r_o     (shf_r),
        .c_o     (shf_c)
    );

    // Register bank: PC comes out of reset at PC_RESET, rest cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                bank_q[i] <= '0;
            end
            bank_q[ADDR_WIDTH'(PC_IDX)] <= MAX_WIDTH'(PC_RESET);
        end else if (bank_wr_en) begin
            bank_q[BusC_addr] <= busc;
        end
    end

    // Internal RAM, no reset; write address is the pre-edge MAR
    always_ff @(posedge clk) begin
        if (wr_rdn) begin
            ram_q[mar_q] <= shf_r;
        end
    end

    // IR/MAR/MDR/flags; sclr wins over every individual enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            {c_q, n_q, p_q, z_q} <= 4'b0000;
        end else if (sclr) begin
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            {c_q, n_q, p_q, z_q} <= 4'b0000;
        end else begin
            if (ir_en)              ir_q  <= mdr_q;
            if (mar_en)             mar_q <= shf_r;
            if (mdr_en && !wr_rdn)  mdr_q <= ram_q[mar_q];
            if (enaf) begin
                c_q <= shf_c;
                n_q <= shf_r[MAX_WIDTH-1];
                p_q <= ~^shf_r;
                z_q <= (shf_r == '0);
            end
        end
    end

    assign C      = c_q;
    assign N      = n_q;
    assign P      = p_q;
    assign Z      = z_q;
    assign out_IR = ir_q[MAX_WIDTH-1 -: 5];

    logic unused_ir;
    assign unused_ir = ^ir_q[MAX_WIDTH-6:0];

endmodule

// File: tb/tb_pdua_datapath.sv
// Scoreboard bench for pdua_datapath: directed control words, expected
// values queued after each edge and compared by an independent monitor.
module tb_pdua_datapath;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 3;

    localparam int K_REG = 0;
    localparam int K_FLG = 1;
    localparam int K_IR  = 2;
    localparam int K_MAR = 3;
    localparam int K_MDR = 4;

    logic          clk, rst;
    logic          wr_rdn, enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en, mdr_alu_n;
    logic [2:0]    selop;
    logic [1:0]    shamt;
    logic [AW-1:0] BusB_addr, BusC_addr;
    logic          C, N, P, Z;
    logic [4:0]    out_IR;

    typedef struct {
        string      name;
        int         kind;
        int         idx;
        logic [7:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pdua_datapath #(.MAX_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_rdn     (wr_rdn),
        .enaf       (enaf),
        .selop      (selop),
        .shamt      (shamt),
        .C          (C),
        .N          (N),
        .P          (P),
        .Z          (Z),
        .bank_wr_en (bank_wr_en),
        .BusB_addr  (BusB_addr),
        .BusC_addr  (BusC_addr),
        .sclr       (sclr),
        .ir_en      (ir_en),
        .mar_en     (mar_en),
        .mdr_en     (mdr_en),
        .mdr_alu_n  (mdr_alu_n),
        .out_IR     (out_IR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] observe(input int kind, input int idx);
        logic [7:0] v;
        v = 8'h00;
        case (kind)
            K_REG: v = dut.bank_q[idx];
            K_FLG: v = {4'b0000, C, N, P, Z};
            K_IR:  v = {3'b000, out_IR};
            K_MAR: v = dut.mar_q;
            K_MDR: v = dut.mdr_q;
            default: v = 8'hxx;
        endcase
        return v;
    endfunction

    task automatic expect_v(input string name, input int kind, input int idx, input logic [7:0] v);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = v;
        sb_q.push_back(c);
    endtask

    // flags packed as {C,N,P,Z}
    task automatic expect_flags(input string name, input logic [3:0] f);
        expect_v(name, K_FLG, 0, {4'b0000, f});
    endtask

    task automatic idle();
        wr_rdn = 0; enaf = 0; bank_wr_en = 0; sclr = 0; ir_en = 0;
        mar_en = 0; mdr_en = 0; mdr_alu_n = 0;
        selop = 3'b000; shamt = 2'b00; BusB_addr = '0; BusC_addr = '0;
    endtask

    // One control word applied for exactly one rising edge
    task automatic step(input logic [2:0] sel, input logic [1:0] sh, input int b, input int c,
                        input logic wb, input logic ef, input logic ma, input logic wr,
                        input logic md, input logic ir, input logic mx, input logic sc);
        @(negedge clk);
        selop = sel; shamt = sh; BusB_addr = AW'(b); BusC_addr = AW'(c);
        bank_wr_en = wb; enaf = ef; mar_en = ma; wr_rdn = wr;
        mdr_en = md; ir_en = ir; mdr_alu_n = mx; sclr = sc;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare everything queued against the settled DUT state
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                chk_t c;
                logic [7:0] got;
                c   = sb_q.pop_front();
                got = observe(c.kind, c.idx);
                n_checks++;
                if (got === c.exp) n_pass++;
                else $display("FAIL %s: got 0x%02h expected 0x%02h", c.name, got, c.exp);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        expect_v("rst_pc", K_REG, 0, 8'h01);
        for (int i = 1; i < 8; i++) expect_v($sformatf("rst_reg%0d", i), K_REG, i, 8'h00);
        expect_flags("rst_flags", 4'b0000);
        expect_v("rst_ir", K_IR, 0, 8'h00);
        expect_v("rst_mar", K_MAR, 0, 8'h00);
        expect_v("rst_mdr", K_MDR, 0, 8'h00);

        //   sel     sh     b  c  wb ef ma wr md ir mx sc
        step(3'b011, 2'b00, 3, 7, 1, 1, 0, 0, 0, 0, 0, 0);   // ACC = 0 | 0
        expect_v("or_zero_acc", K_REG, 7, 8'h00);
        expect_flags("or_zero_flags", 4'b0011);

        step(3'b110, 2'b00, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);   // A = PC + 1
        expect_v("inc_a", K_REG, 3, 8'h02);
        expect_v("inc_pc_hold", K_REG, 0, 8'h01);
        expect_flags("inc_flags_hold", 4'b0011);

        step(3'b011, 2'b00, 3, 7, 1, 1, 0, 0, 0, 0, 0, 0);   // ACC = ACC | A
        expect_v("or_acc", K_REG, 7, 8'h02);
        expect_flags("or_flags", 4'b0000);

        step(3'b000, 2'b00, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);   // MAR = A
        expect_v("mar_load", K_MAR, 0, 8'h02);

        step(3'b000, 2'b00, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // RAM[2] = 2
        expect_v("mdr_idle", K_MDR, 0, 8'h00);

        step(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // MDR = RAM[2]
        expect_v("mdr_read", K_MDR, 0, 8'h02);

        step(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   // IR = MDR
        expect_v("ir_small", K_IR, 0, 8'h00);

        step(3'b111, 2'b00, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0);   // RAM[2] = ~A, MDR holds
        expect_v("mdr_hold_on_write", K_MDR, 0, 8'h02);

        step(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);   // MDR new, IR gets old MDR
        expect_v("mdr_read_fd", K_MDR, 0, 8'hFD);
        expect_v("ir_old_mdr", K_IR, 0, 8'h00);

        step(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   // IR = 0xFD
        expect_v("ir_fd", K_IR, 0, 8'h1F);

        step(3'b100, 2'b00, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0);   // reg6 = MDR
        expect_v("busc_mdr", K_REG, 6, 8'hFD);

        for (int i = 0; i < 5; i++) step(3'b100, 2'b00, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        step(3'b100, 2'b00, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0);   // ACC doubled to 0x80
        expect_v("add_double", K_REG, 7, 8'h80);
        expect_flags("add_double_flags", 4'b0100);

        step(3'b100, 2'b00, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);   // ACC = 0x80 + 1
        expect_v("add_pc", K_REG, 7, 8'h81);
        expect_flags("add_pc_flags", 4'b0110);

        step(3'b111, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);   // reg1 = ~PC
        expect_v("not_pc", K_REG, 1, 8'hFE);
        expect_flags("not_flags", 4'b0100);

        step(3'b101, 2'b00, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);   // 0x81 - 0xFE borrows
        expect_v("sub_borrow", K_REG, 2, 8'h83);
        expect_flags("sub_borrow_flags", 4'b1100);

        step(3'b100, 2'b00, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0);   // 0x81 + 0xFE wraps
        expect_v("add_wrap", K_REG, 4, 8'h7F);
        expect_flags("add_wrap_flags", 4'b1000);

        step(3'b101, 2'b00, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0);   // ACC - ACC, no borrow
        expect_flags("sub_equal_flags", 4'b0011);

        step(3'b010, 2'b00, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);   // 0x81 ^ 0xFE
        expect_v("xor", K_REG, 5, 8'h7F);

        step(3'b001, 2'b00, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0);   // 0x81 & 0x83
        expect_v("and", K_REG, 3, 8'h81);

`ifdef PDUA_SHIFTER_EN
        step(3'b000, 2'b01, 7, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_v("sll", K_REG, 5, 8'h02);
        expect_flags("sll_flags", 4'b1000);
        step(3'b000, 2'b10, 7, 6, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_v("srl", K_REG, 6, 8'h40);
        expect_flags("srl_flags", 4'b1000);
        step(3'b000, 2'b11, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_v("ror", K_REG, 1, 8'hC0);
        expect_flags("ror_flags", 4'b1110);
`else
        step(3'b000, 2'b01, 7, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_v("sll_off", K_REG, 5, 8'h81);
        expect_flags("sll_off_flags", 4'b0110);
        step(3'b100, 2'b10, 7, 6, 1, 1, 0, 0, 0, 0, 0, 0);   // 0x81+0x81, carry from ALU
        expect_v("srl_off", K_REG, 6, 8'h02);
        expect_flags("srl_off_flags", 4'b1000);
        step(3'b000, 2'b11, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_v("ror_off", K_REG, 1, 8'h81);
        expect_flags("ror_off_flags", 4'b0110);
`endif

        step(3'b000, 2'b00, 7, 0, 0, 1, 1, 0, 1, 1, 0, 1);   // sclr beats all enables
        expect_flags("sclr_flags", 4'b0000);
        expect_v("sclr_ir", K_IR, 0, 8'h00);
        expect_v("sclr_mar", K_MAR, 0, 8'h00);
        expect_v("sclr_mdr", K_MDR, 0, 8'h00);
        expect_v("sclr_acc_hold", K_REG, 7, 8'h81);
        expect_v("sclr_pc_hold", K_REG, 0, 8'h01);

        step(3'b110, 2'b00, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);   // ACC = PC + 1
        expect_v("pre_rst_acc", K_REG, 7, 8'h02);
        @(negedge clk);
        #1;
        idle();
        rst = 1'b1;                                          // mid-cycle async reset
        #2;
        rst = 1'b0;
        expect_v("arst_acc", K_REG, 7, 8'h00);
        expect_v("arst_a", K_REG, 3, 8'h00);
        expect_v("arst_pc", K_REG, 0, 8'h01);

        step(3'b110, 2'b00, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);   // A = PC + 1 after reset
        expect_v("post_rst_inc", K_REG, 3, 8'h02);
        expect_flags("post_rst_flags", 4'b0000);

        idle();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
